// File: rtl/pipelined_barrel_shifter.sv
// Logarithmic barrel shifter (LSR/LSL/ASR/ROR) with one registered mux stage per
// shift-amount bit, largest shift first, and valid/ready flow control on both ends.
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    MODE_LSR = 2'd0,
    MODE_LSL = 2'd1,
    MODE_ASR = 2'd2,
    MODE_ROR = 2'd3
  } mode_e;

  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       mode,
    input logic             sign,
    input int               k
  );
    logic [WIDTH-1:0] res;
    unique case (mode_e'(mode))
      MODE_LSR: res = d >> k;
      MODE_LSL: res = d << k;
      MODE_ASR: res = (d >> k) | ({WIDTH{sign}} & ~({WIDTH{1'b1}} >> k));
      MODE_ROR: res = (d >> k) | (d << (WIDTH - k));
      default:  res = d;
    endcase
    return res;
  endfunction

  // Index 0 is the pipeline input, index g+1 is the output register of stage g.
  logic             st_valid [SHW+1];
  logic [WIDTH-1:0] st_data  [SHW+1];
  logic [SHW-1:0]   st_shamt [SHW+1];
  logic [1:0]       st_mode  [SHW+1];
  logic             st_sign  [SHW+1];

  logic advance;

  assign advance  = !st_valid[SHW] || out_ready;
  assign in_ready = advance;

  assign st_valid[0] = in_valid;
  assign st_data[0]  = in_data;
  assign st_shamt[0] = in_shamt;
  assign st_mode[0]  = in_mode;
  // ASR fills from the operand's original sign, not the partially shifted word.
  assign st_sign[0]  = in_data[WIDTH-1];

  for (genvar g = 0; g < SHW; g++) begin : g_stage
    localparam int K = 1 << (SHW - 1 - g);

    logic             valid_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   shamt_q;
    logic [1:0]       mode_q;
    logic             sign_q;

    always_comb begin
      data_d = st_data[g];
      if (st_shamt[g][SHW-1-g]) begin
        data_d = shift_by(st_data[g], st_mode[g], st_sign[g], K);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        shamt_q <= '0;
        mode_q  <= '0;
        sign_q  <= 1'b0;
      end else if (advance) begin
        valid_q <= st_valid[g];
        data_q  <= data_d;
        shamt_q <= st_shamt[g];
        mode_q  <= st_mode[g];
        sign_q  <= st_sign[g];
      end
    end

    assign st_valid[g+1] = valid_q;
    assign st_data[g+1]  = data_q;
    assign st_shamt[g+1] = shamt_q;
    assign st_mode[g+1]  = mode_q;
    assign st_sign[g+1]  = sign_q;
  end

  assign out_valid = st_valid[SHW];
  assign out_data  = st_data[SHW];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed and scoreboarded bench for pipelined_barrel_shifter at WIDTH=8 and WIDTH=32.
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       v8, r8, ov8, or8;
  logic [7:0] d8, od8;
  logic [2:0] s8;
  logic [1:0] m8;

  logic        v32, r32, ov32, or32;
  logic [31:0] d32, od32;
  logic [4:0]  s32;
  logic [1:0]  m32;

  pipelined_barrel_shifter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(v8), .in_ready(r8), .in_data(d8), .in_shamt(s8), .in_mode(m8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8)
  );

  pipelined_barrel_shifter #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .in_valid(v32), .in_ready(r32), .in_data(d32), .in_shamt(s32), .in_mode(m32),
    .out_valid(ov32), .out_ready(or32), .out_data(od32)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  it_d [8];
  logic [2:0]  it_s [8];
  logic [1:0]  it_m [8];
  logic [7:0]  it_e [8];
  logic [31:0] sb [$];
  logic [31:0] tmp;
  logic [31:0] held;
  logic        stalled, in_acc, out_acc, acc;
  int          cnt, sent, recv, cyc;

  // Bitwise reference: each result bit names the source bit it comes from.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s,
                                            input int mode, input int w);
    logic [31:0] r;
    int src;
    r = '0;
    for (int b = 0; b < w; b++) begin
      src = b + s;
      case (mode)
        0:       r[b] = (src < w) ? d[src] : 1'b0;
        1:       r[b] = (b >= s) ? d[b-s] : 1'b0;
        2:       r[b] = (src < w) ? d[src] : d[w-1];
        default: r[b] = d[src % w];
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_items();
    for (int k = 0; k < 8; k++) begin
      it_d[k] = 8'($urandom);
      it_s[k] = 3'($urandom_range(0, 7));
      it_m[k] = 2'($urandom_range(0, 3));
      tmp     = ref_shift({24'h0, it_d[k]}, int'(it_s[k]), int'(it_m[k]), 8);
      it_e[k] = tmp[7:0];
    end
  endtask

  task automatic drive_item(input int k);
    v8 = 1'b1;
    d8 = it_d[k];
    s8 = it_s[k];
    m8 = it_m[k];
  endtask

  task automatic send8(input string tag, input logic [7:0] d, input logic [2:0] s,
                       input logic [1:0] m, input logic [7:0] exp);
    int lat;
    v8 = 1'b1; d8 = d; s8 = s; m8 = m;
    tick();
    v8  = 1'b0;
    lat = 1;
    while (!ov8 && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check(tag, {24'h0, od8}, {24'h0, exp});
  endtask

  task automatic send32(input string tag, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] m, input logic [31:0] exp);
    int lat;
    v32 = 1'b1; d32 = d; s32 = s; m32 = m;
    tick();
    v32 = 1'b0;
    lat = 1;
    while (!ov32 && lat < 12) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd5);
    check(tag, od32, exp);
  endtask

  initial begin
    rst = 1'b1;
    v8 = 1'b0; d8 = '0; s8 = '0; m8 = '0; or8 = 1'b1;
    v32 = 1'b0; d32 = '0; s32 = '0; m32 = '0; or32 = 1'b1;
    #12;
    check("rst_ov8", {31'h0, ov8}, 32'd0);
    check("rst_od8", {24'h0, od8}, 32'd0);
    check("rst_ov32", {31'h0, ov32}, 32'd0);
    check("rst_od32", od32, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_ir8", {31'h0, r8}, 32'd1);
    check("rst_ir32", {31'h0, r32}, 32'd1);

    // Test 1: B6 by 3 in each mode
    send8("t1_lsr", 8'hB6, 3'd3, 2'd0, 8'h16);
    send8("t1_lsl", 8'hB6, 3'd3, 2'd1, 8'hB0);
    send8("t1_asr", 8'hB6, 3'd3, 2'd2, 8'hF6);
    send8("t1_ror", 8'hB6, 3'd3, 2'd3, 8'hD6);

    // Test 2: boundary shift amounts
    send8("t2_lsr7", 8'h80, 3'd7, 2'd0, 8'h01);
    send8("t2_asr7", 8'h80, 3'd7, 2'd2, 8'hFF);
    send8("t2_ror7", 8'h80, 3'd7, 2'd3, 8'h01);
    send8("t2_lsl7", 8'h80, 3'd7, 2'd1, 8'h00);
    for (int m = 0; m < 4; m++) send8("t2_zero", 8'h80, 3'd0, 2'(m), 8'h80);
    tick();

    // Test 3: back-to-back stream of 8
    gen_items();
    drive_item(0);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c < 8) drive_item(c);
      else v8 = 1'b0;
      if (c >= 3 && c <= 10) begin
        check("t3_valid", {31'h0, ov8}, 32'd1);
        check("t3_data", {24'h0, od8}, {24'h0, it_e[c-3]});
      end else begin
        check("t3_idle", {31'h0, ov8}, 32'd0);
      end
    end

    // Test 4: 5-cycle output stall with 4 items
    gen_items();
    drive_item(0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      drive_item(c);
    end
    or8 = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      check("t4_hold_valid", {31'h0, ov8}, 32'd1);
      check("t4_hold_data", {24'h0, od8}, {24'h0, it_e[0]});
      check("t4_hold_ready", {31'h0, r8}, 32'd0);
    end
    tick();
    or8 = 1'b1;
    #1;
    cnt = 0;
    for (int q = 0; q < 12; q++) begin
      if (ov8) begin
        if (cnt < 4) check("t4_drain", {24'h0, od8}, {24'h0, it_e[cnt]});
        else check("t4_extra", {31'h0, ov8}, 32'd0);
        cnt++;
      end
      acc = v8 && r8;
      tick();
      if (acc) v8 = 1'b0;
    end
    check("t4_count", 32'(cnt), 32'd4);

    // Test 5: reset with items in flight
    gen_items();
    drive_item(0);
    for (int c = 1; c <= 2; c++) begin
      tick();
      drive_item(c);
    end
    tick();
    v8 = 1'b0;
    check("t5_pre_valid", {31'h0, ov8}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_async_valid", {31'h0, ov8}, 32'd0);
    check("t5_async_data", {24'h0, od8}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("t5_ready", {31'h0, r8}, 32'd1);
    check("t5_no_stale", {31'h0, ov8}, 32'd0);
    send8("t5_lsl", 8'h0F, 3'd4, 2'd1, 8'hF0);

    // Test 6: WIDTH=32 latency, boundaries, then random stream
    send32("t6_ror31", 32'h8000_0001, 5'd31, 2'd3, 32'h0000_0003);
    send32("t6_asr31", 32'h8000_0000, 5'd31, 2'd2, 32'hFFFF_FFFF);
    send32("t6_lsr31", 32'h8000_0000, 5'd31, 2'd0, 32'h0000_0001);
    send32("t6_lsl16", 32'h1234_5678, 5'd16, 2'd1, 32'h5678_0000);
    tick();
    sent = 0; recv = 0; cyc = 0;
    v32  = 1'b1;
    d32  = $urandom;
    s32  = 5'($urandom_range(0, 31));
    m32  = 2'($urandom_range(0, 3));
    or32 = 1'b1;
    #1;
    while ((sent < 1000 || recv < 1000) && cyc < 20000) begin
      in_acc  = v32 && r32;
      out_acc = ov32 && or32;
      stalled = ov32 && !or32;
      held    = od32;
      if (out_acc) begin
        if (sb.size() == 0) check("t6_empty", 32'(sb.size()), 32'd1);
        else check("t6_data", od32, sb.pop_front());
        recv++;
      end
      if (in_acc) begin
        sb.push_back(ref_shift(d32, int'(s32), int'(m32), 32));
        sent++;
      end
      tick();
      cyc++;
      if (stalled) begin
        check("t6_hold_valid", {31'h0, ov32}, 32'd1);
        check("t6_hold_data", od32, held);
      end
      if (in_acc || !v32) begin
        if (sent < 1000) begin
          v32 = ($urandom_range(0, 3) != 0);
          d32 = $urandom;
          s32 = 5'($urandom_range(0, 31));
          m32 = 2'($urandom_range(0, 3));
        end else begin
          v32 = 1'b0;
        end
      end
      or32 = ($urandom_range(0, 3) != 0);
      #1;
    end
    check("t6_recv", 32'(recv), 32'd1000);
    check("t6_left", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
